pipeline_ctrl: RTL and testbench

- Central hazard/sequencing controller for the 5-stage core. Drives the stall_in/flush_in pairs of fetch, decode, execute and mem.
- Resolves four conditions: load-use hazards into execute, branch mispredicts from mem, FENCE drain, and data-memory wait states.
- Stall/flush outputs are combinational from inputs plus registered FSM state.

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/pipeline_ctrl_hazard_detect.sv | 22 ++
 rtl/pipeline_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller and the decode/execute stages.
// Optional feature macro used by pipeline_ctrl: PIPE_CTRL_PERF_EN.
package pipeline_ctrl_pkg;

    localparam int REG_W = 9;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        CTRL_RUN   = 2'd0,
        CTRL_FLUSH = 2'd1,
        CTRL_FENCE = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use comparator: decode source ids against a load's
// destination in execute. Register 0 never creates a dependency.
module pipeline_ctrl_hazard_detect #(
    parameter int REG_W = pipeline_ctrl_pkg::REG_W
) (
    input  logic             dec_valid_in,
    input  logic [REG_W-1:0] dec_rs1_in,
    input  logic [REG_W-1:0] dec_rs2_in,
    input  logic             ex_valid_in,
    input  logic             ex_mem_read_in,
    input  logic [REG_W-1:0] ex_rd_in,
    output logic             hazard_out
);

    logic rd_nonzero;
    logic rs_match;

    assign rd_nonzero = (ex_rd_in != '0);
    assign rs_match   = (ex_rd_in == dec_rs1_in) || (ex_rd_in == dec_rs2_in);
    assign hazard_out = dec_valid_in && ex_valid_in && ex_mem_read_in && rd_nonzero && rs_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: load-use, mispredict
// flush, FENCE drain and memory wait states. Define PIPE_CTRL_PERF_EN for perf counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int REG_W        = pipeline_ctrl_pkg::REG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid_in,
    input  logic [REG_W-1:0] dec_rs1_in,
    input  logic [REG_W-1:0] dec_rs2_in,
    input  logic             dec_fence_in,
    input  logic             ex_valid_in,
    input  logic             ex_mem_read_in,
    input  logic [REG_W-1:0] ex_rd_in,
    input  logic             mem_valid_in,
    input  logic             wb_valid_in,
    input  logic             mem_busy_in,
    input  logic             mispredict_in,
    output logic             fetch_stall_out,
    output logic             decode_stall_out,
    output logic             execute_stall_out,
    output logic             mem_stall_out,
    output logic             fetch_flush_out,
    output logic             decode_flush_out,
    output logic             execute_flush_out,
    output logic             mem_flush_out,
    output logic [1:0]       state_out
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_stall_cycles_out,
    output logic [31:0]      perf_flush_events_out,
    output logic [31:0]      perf_loaduse_out
`endif
);

    // The counter holds the FLUSH-state cycles still to come, so the
    // mispredict cycle plus the FLUSH cycles total FLUSH_CYCLES.
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;
    logic             pipe_empty;
    logic             fence_req;
    logic             loaduse_taken;

    assign pipe_empty = !ex_valid_in && !mem_valid_in && !wb_valid_in;
    assign fence_req  = dec_valid_in && dec_fence_in;

    pipeline_ctrl_hazard_detect #(
        .REG_W(REG_W)
    ) u_hazard (
        .dec_valid_in  (dec_valid_in),
        .dec_rs1_in    (dec_rs1_in),
        .dec_rs2_in    (dec_rs2_in),
        .ex_valid_in   (ex_valid_in),
        .ex_mem_read_in(ex_mem_read_in),
        .ex_rd_in      (ex_rd_in),
        .hazard_out    (hazard)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CTRL_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mem_busy_in) begin
            state_d = state_q;
        end else if (mispredict_in) begin
            if (FLUSH_CYCLES == 1) begin
                state_d = CTRL_RUN;
                cnt_d   = '0;
            end else begin
                state_d = CTRL_FLUSH;
                cnt_d   = FLUSH_LOAD;
            end
        end else begin
            case (state_q)
                CTRL_FLUSH: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = CTRL_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                CTRL_FENCE: begin
                    if (pipe_empty) state_d = CTRL_RUN;
                end
                default: begin
                    if (fence_req && !pipe_empty) state_d = CTRL_FENCE;
                end
            endcase
        end
    end

    always_comb begin
        fetch_stall_out   = 1'b0;
        decode_stall_out  = 1'b0;
        execute_stall_out = 1'b0;
        mem_stall_out     = 1'b0;
        fetch_flush_out   = 1'b0;
        decode_flush_out  = 1'b0;
        execute_flush_out = 1'b0;
        mem_flush_out     = 1'b0;
        loaduse_taken     = 1'b0;
        if (!rst_n) begin
            fetch_flush_out   = 1'b1;
            decode_flush_out  = 1'b1;
            execute_flush_out = 1'b1;
            mem_flush_out     = 1'b1;
        end else if (mem_busy_in) begin
            fetch_stall_out   = 1'b1;
            decode_stall_out  = 1'b1;
            execute_stall_out = 1'b1;
            mem_stall_out     = 1'b1;
        end else if (mispredict_in || state_q == CTRL_FLUSH) begin
            fetch_flush_out   = 1'b1;
            decode_flush_out  = 1'b1;
            execute_flush_out = 1'b1;
        end else if (state_q == CTRL_FENCE || fence_req) begin
            if (!pipe_empty) begin
                fetch_stall_out   = 1'b1;
                decode_stall_out  = 1'b1;
                execute_flush_out = 1'b1;
            end
        end else if (hazard) begin
            fetch_stall_out   = 1'b1;
            decode_stall_out  = 1'b1;
            execute_flush_out = 1'b1;
            loaduse_taken     = 1'b1;
        end
    end

    assign state_out = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_loaduse_q, perf_loaduse_d;
    logic        stall_any;

    assign stall_any = fetch_stall_out | decode_stall_out | execute_stall_out | mem_stall_out;

    always_comb begin
        perf_stall_d   = perf_stall_q + {31'd0, stall_any};
        perf_flush_d   = perf_flush_q + {31'd0, mispredict_in && !mem_busy_in};
        perf_loaduse_d = perf_loaduse_q + {31'd0, loaduse_taken};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q   <= '0;
            perf_flush_q   <= '0;
            perf_loaduse_q <= '0;
        end else begin
            perf_stall_q   <= perf_stall_d;
            perf_flush_q   <= perf_flush_d;
            perf_loaduse_q <= perf_loaduse_d;
        end
    end

    assign perf_stall_cycles_out = perf_stall_q;
    assign perf_flush_events_out = perf_flush_q;
    assign perf_loaduse_out      = perf_loaduse_q;
`else
    logic unused_loaduse;
    assign unused_loaduse = loaduse_taken;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (FLUSH_CYCLES=3).
module tb_pipeline_ctrl;

    localparam logic [7:0] O_IDLE  = 8'b0000_0000;
    localparam logic [7:0] O_RST   = 8'b0000_1111;
    localparam logic [7:0] O_BUSY  = 8'b1111_0000;
    localparam logic [7:0] O_FLUSH = 8'b0000_1110;
    localparam logic [7:0] O_BUBL  = 8'b1100_0010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dec_valid, dec_fence, ex_valid, ex_mem_read, mem_valid, wb_valid, mem_busy, mispredict;
    logic [8:0] dec_rs1, dec_rs2, ex_rd;
    logic       fs, ds, es, ms, ff, df, ef, mf;
    logic [1:0] state;
    logic [7:0] outs;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall, perf_flush, perf_loaduse;
`endif

    int checks = 0;
    int failures = 0;

    assign outs = {fs, ds, es, ms, ff, df, ef, mf};

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .FLUSH_CYCLES(3),
        .REG_W(9)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid_in(dec_valid), .dec_rs1_in(dec_rs1), .dec_rs2_in(dec_rs2),
        .dec_fence_in(dec_fence), .ex_valid_in(ex_valid), .ex_mem_read_in(ex_mem_read),
        .ex_rd_in(ex_rd), .mem_valid_in(mem_valid), .wb_valid_in(wb_valid),
        .mem_busy_in(mem_busy), .mispredict_in(mispredict),
        .fetch_stall_out(fs), .decode_stall_out(ds), .execute_stall_out(es), .mem_stall_out(ms),
        .fetch_flush_out(ff), .decode_flush_out(df), .execute_flush_out(ef), .mem_flush_out(mf),
        .state_out(state)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles_out(perf_stall),
        .perf_flush_events_out(perf_flush),
        .perf_loaduse_out(perf_loaduse)
`endif
    );

    // Mismatches are reported with both values; every comparison is counted here.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; outputs are examined 1ns later.
    task automatic applyStimulus(input logic dv, input logic [8:0] rs1, input logic [8:0] rs2,
                                 input logic fence, input logic exv, input logic mrd,
                                 input logic [8:0] rd, input logic memv, input logic wbv,
                                 input logic busy, input logic mp);
        dec_valid = dv; dec_rs1 = rs1; dec_rs2 = rs2; dec_fence = fence;
        ex_valid = exv; ex_mem_read = mrd; ex_rd = rd;
        mem_valid = memv; wb_valid = wbv; mem_busy = busy; mispredict = mp;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect2(input string tag, input logic [7:0] o, input logic [1:0] s);
        checkOutput({tag, "_outs"}, {24'd0, outs}, {24'd0, o});
        checkOutput({tag, "_state"}, {30'd0, state}, {30'd0, s});
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #10;
        expect2("reset_held", O_RST, 2'd0);
        rst_n = 1'b1;
        #1;
        expect2("idle", O_IDLE, 2'd0);
        tick();

        // load-use through rs2, then through rs1, then bubble gone
        applyStimulus(1, 9'd3, 9'd5, 0, 1, 1, 9'd5, 1, 1, 0, 0);
        expect2("lu_rs2", O_BUBL, 2'd0);
        tick();
        applyStimulus(1, 9'd3, 9'd5, 0, 0, 1, 9'd5, 1, 1, 0, 0);
        expect2("lu_clear", O_IDLE, 2'd0);
        tick();
        applyStimulus(1, 9'd7, 9'd2, 0, 1, 1, 9'd7, 0, 0, 0, 0);
        expect2("lu_rs1", O_BUBL, 2'd0);
        tick();

        // no-hazard cases
        applyStimulus(1, 9'd0, 9'd4, 0, 1, 1, 9'd0, 0, 0, 0, 0);
        expect2("rd_zero", O_IDLE, 2'd0);
        applyStimulus(0, 9'd5, 9'd1, 0, 1, 1, 9'd5, 0, 0, 0, 0);
        expect2("dec_invalid", O_IDLE, 2'd0);
        applyStimulus(1, 9'd5, 9'd1, 0, 1, 0, 9'd5, 0, 0, 0, 0);
        expect2("not_load", O_IDLE, 2'd0);
        tick();

        // mispredict: three flush cycles, state 0,1,1 then 0
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1);
        expect2("mp_c0", O_FLUSH, 2'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0);
        expect2("mp_c1", O_FLUSH, 2'd1);
        tick();
        expect2("mp_c2", O_FLUSH, 2'd1);
        tick();
        expect2("mp_done", O_IDLE, 2'd0);

        // fence drain: mem and wb empty one cycle apart
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        expect2("fence_entry", O_BUBL, 2'd0);
        tick();
        expect2("fence_wait1", O_BUBL, 2'd2);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        expect2("fence_wait2", O_BUBL, 2'd2);
        tick();
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        expect2("fence_release", O_IDLE, 2'd2);
        tick();
        expect2("fence_run_empty", O_IDLE, 2'd0);
        tick();

        // fence with a load-use in the same cycle enters FENCE, then busy freezes it
        applyStimulus(1, 9'd1, 9'd5, 1, 1, 1, 9'd5, 0, 0, 0, 0);
        expect2("fence_lu", O_BUBL, 2'd0);
        tick();
        expect2("fence_lu_state", O_BUBL, 2'd2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 9'd1, 9'd5, 1, 1, 1, 9'd5, 0, 0, 1, (i == 1) ? 1'b1 : 1'b0);
            expect2($sformatf("busy_c%0d", i), O_BUSY, 2'd2);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        expect2("busy_mp_again", O_FLUSH, 2'd2);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect2("abandon_c1", O_FLUSH, 2'd1);
        tick();
        expect2("abandon_c2", O_FLUSH, 2'd1);
        tick();
        expect2("abandon_done", O_IDLE, 2'd0);

        // second mispredict during FLUSH reloads the counter
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        expect2("reload_c1", O_FLUSH, 2'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect2("reload_c2", O_FLUSH, 2'd1);
        tick();
        expect2("reload_c3", O_FLUSH, 2'd1);
        tick();
        expect2("reload_done", O_IDLE, 2'd0);

        // async reset in the middle of FLUSH
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect2("pre_reset_flush", O_FLUSH, 2'd1);
        rst_n = 1'b0;
        #1;
        expect2("async_reset", O_RST, 2'd0);
        tick();
        #2;
        rst_n = 1'b1;
        #1;
        expect2("after_reset", O_IDLE, 2'd0);
`ifdef PIPE_CTRL_PERF_EN
        checkOutput("perf_stall", perf_stall, 32'd0);
        checkOutput("perf_flush", perf_flush, 32'd0);
        checkOutput("perf_loaduse", perf_loaduse, 32'd0);
`endif
        tick();
        expect2("after_reset_edge", O_IDLE, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
